// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage register:
// occupancy width, control-field bit packing and entry operations.
package pipe_pkg;

   localparam int PIPE_OCC_W = 2;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMTOREG  = 1;
   localparam int CTRL_MEMREAD   = 2;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_BRANCH    = 4;
   localparam int CTRL_PREDICT   = 5;
   localparam int CTRL_ALUSRC    = 6;
   localparam int CTRL_ALUOP_LSB = 7;
   localparam int CTRL_ALUOP_MSB = 9;

   typedef enum logic [1:0] {
      ENT_HOLD,
      ENT_LOAD,
      ENT_POP,
      ENT_CLR
   } ent_op_e;

   function automatic logic [PIPE_OCC_W-1:0] occ_sum(
      input logic a,
      input logic b
   );
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One stage entry: valid bit, control and data fields.
// Pop invalidates and zeroes control but keeps data; clear zeroes everything.
module pipe_skid_entry
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 10,
   parameter int DATA_W = 128
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  ent_op_e           op_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_data  <= '0;
      end else begin
         case (op_i)
            ENT_LOAD: begin
               r_valid <= 1'b1;
               r_ctrl  <= ctrl_i;
               r_data  <= data_i;
            end
            ENT_POP: begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
            end
            ENT_CLR: begin
               r_valid <= 1'b0;
               r_ctrl  <= '0;
               r_data  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign valid_o = r_valid;
   assign ctrl_o  = r_ctrl;
   assign data_o  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake and flush.
// Define PIPE_SKID_EN for a second (skid) entry that registers in_ready_o.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 10,
   parameter int DATA_W = 128
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  flush_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [CTRL_W-1:0]     in_ctrl_i,
   input  logic [DATA_W-1:0]     in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [CTRL_W-1:0]     out_ctrl_o,
   output logic [DATA_W-1:0]     out_data_o,
   output logic [PIPE_OCC_W-1:0] occupancy_o
);

   ent_op_e           w_main_op;
   logic [CTRL_W-1:0] w_main_ctrl_in;
   logic [DATA_W-1:0] w_main_data_in;
   logic              w_main_valid;
   logic              w_acc;
   logic              w_del;

   assign w_acc = in_valid_i && in_ready_o;
   assign w_del = w_main_valid && out_ready_i;

`ifdef PIPE_SKID_EN
   ent_op_e           w_skid_op;
   logic              w_skid_valid;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;

   // Ready comes straight from the skid flop, never from out_ready_i.
   assign in_ready_o  = !w_skid_valid;
   assign occupancy_o = occ_sum(w_main_valid, w_skid_valid);

   always_comb begin
      w_main_op      = ENT_HOLD;
      w_main_ctrl_in = in_ctrl_i;
      w_main_data_in = in_data_i;
      w_skid_op      = ENT_HOLD;
      if (flush_i) begin
         w_main_op = ENT_CLR;
         w_skid_op = ENT_CLR;
      end else begin
         if (w_del && w_skid_valid) begin
            w_main_op      = ENT_LOAD;
            w_main_ctrl_in = w_skid_ctrl;
            w_main_data_in = w_skid_data;
            w_skid_op      = ENT_POP;
         end else if (w_acc && (!w_main_valid || w_del)) begin
            w_main_op = ENT_LOAD;
         end else if (w_del) begin
            w_main_op = ENT_POP;
         end
         if (w_acc && w_main_valid && !w_del) begin
            w_skid_op = ENT_LOAD;
         end
      end
   end

   pipe_skid_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .op_i    (w_skid_op),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (w_skid_valid),
      .ctrl_o  (w_skid_ctrl),
      .data_o  (w_skid_data)
   );
`else
   assign in_ready_o  = !w_main_valid || out_ready_i;
   assign occupancy_o = occ_sum(w_main_valid, 1'b0);

   always_comb begin
      w_main_op      = ENT_HOLD;
      w_main_ctrl_in = in_ctrl_i;
      w_main_data_in = in_data_i;
      if (flush_i) begin
         w_main_op = ENT_CLR;
      end else if (w_acc) begin
         w_main_op = ENT_LOAD;
      end else if (w_del) begin
         w_main_op = ENT_POP;
      end
   end
`endif

   pipe_skid_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
   ) u_main (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .op_i    (w_main_op),
      .ctrl_i  (w_main_ctrl_in),
      .data_i  (w_main_data_in),
      .valid_o (w_main_valid),
      .ctrl_o  (out_ctrl_o),
      .data_o  (out_data_o)
   );

   assign out_valid_o = w_main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed
// corner sequences and a randomized run against a FIFO reference model.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int CW = 10;
   localparam int DW = 128;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occ;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_ctrl_i   (in_ctrl),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_ctrl_o  (out_ctrl),
      .out_data_o  (out_data),
      .occupancy_o (occ)
   );

   task automatic chk(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic expect_out(input string nm, input logic v,
                             input logic [CW-1:0] c, input logic [DW-1:0] d,
                             input logic [1:0] o, input logic rdy);
      chk({nm, ".valid"}, DW'(out_valid), DW'(v));
      chk({nm, ".ctrl"}, DW'(out_ctrl), DW'(c));
      chk({nm, ".data"}, out_data, d);
      chk({nm, ".occ"}, DW'(occ), DW'(o));
      chk({nm, ".ready"}, DW'(in_ready), DW'(rdy));
   endtask

   task automatic drive(input logic f, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic r);
      @(negedge clk);
      flush     = f;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   typedef struct {
      logic          v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic          ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      logic [1:0]    eo;
   } vec_t;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   vec_t  tbl[12];
   beat_t q[$];
   logic [DW-1:0] m_last;

   initial begin
      // ---- vector table: streaming 1..8 then idle with bubble control
      for (int i = 0; i < 8; i++) begin
         tbl[i].v  = 1'b1;
         tbl[i].c  = CW'(i + 1);
         tbl[i].d  = DW'(i + 1);
         tbl[i].ev = (i > 0);
         tbl[i].ec = CW'(i);
         tbl[i].ed = DW'(i);
         tbl[i].eo = (i > 0) ? 2'd1 : 2'd0;
      end
      tbl[8] = '{1'b0, 10'h3FF, '0, 1'b1, 10'd8, DW'(8), 2'd1};
      for (int i = 9; i < 12; i++)
         tbl[i] = '{1'b0, 10'h3FF, '0, 1'b0, 10'd0, DW'(8), 2'd0};

      // ---- reset with live input
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b1;
      in_ctrl = 10'h3FF;
      in_data = '1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.valid", DW'(out_valid), DW'(0));
      chk("rst.ctrl", DW'(out_ctrl), DW'(0));
      chk("rst.data", out_data, '0);
      chk("rst.occ", DW'(occ), DW'(0));
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rst.ready", DW'(in_ready), DW'(1));

      for (int i = 0; i < 12; i++) begin
         drive(1'b0, tbl[i].v, tbl[i].c, tbl[i].d, 1'b1);
         expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec,
                    tbl[i].ed, tbl[i].eo, 1'b1);
      end

      // ---- backpressure A then B
      drive(0, 1, 10'hA, 'hA, 0);
      expect_out("bp0", 0, 0, DW'(8), 0, 1);
      drive(0, 1, 10'hB, 'hB, 0);
      expect_out("bp1", 1, 10'hA, 'hA, 1, CAP == 2);
      drive(0, CAP == 1, 10'hB, 'hB, 0);
      expect_out("bp2", 1, 10'hA, 'hA, 2'(CAP), 0);
      drive(0, CAP == 1, 10'hB, 'hB, 0);
      expect_out("bp3", 1, 10'hA, 'hA, 2'(CAP), 0);
      drive(0, CAP == 1, 10'hB, 'hB, 1);
      expect_out("bp4", 1, 10'hA, 'hA, 2'(CAP), CAP == 1);
      drive(0, 0, 10'h3FF, '0, 1);
      expect_out("bp5", 1, 10'hB, 'hB, 1, 1);
      drive(0, 0, 10'h3FF, '0, 1);
      expect_out("bp6", 0, 0, 'hB, 0, 1);

      // ---- flush with simultaneous input
      drive(0, 1, 10'hA, 'hA, 0);
      expect_out("fl0", 0, 0, 'hB, 0, 1);
      drive(1, 1, 10'hC, 'hC, 0);
      expect_out("fl1", 1, 10'hA, 'hA, 1, CAP == 2);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 10'h3FF, '0, 1);
         expect_out($sformatf("fl%0d", i + 2), 0, 0, '0, 0, 1);
      end

      // ---- asynchronous reset mid-operation
      drive(0, 1, 10'h1, 'h1, 0);
      expect_out("mr0", 0, 0, '0, 0, 1);
      drive(0, 1, 10'h2, 'h2, 0);
      expect_out("mr1", 1, 10'h1, 'h1, 1, CAP == 2);
      drive(0, 0, 10'h3FF, '0, 0);
      expect_out("mr2", 1, 10'h1, 'h1, 2'(CAP), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr.valid", DW'(out_valid), DW'(0));
      chk("mr.ctrl", DW'(out_ctrl), DW'(0));
      chk("mr.data", out_data, '0);
      chk("mr.occ", DW'(occ), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 10'h5, 'h5, 1);
      expect_out("mr3", 0, 0, '0, 0, 1);
      drive(0, 0, 10'h3FF, '0, 1);
      expect_out("mr4", 1, 10'h5, 'h5, 1, 1);

      // ---- randomized run against a FIFO model
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      q.delete();
      m_last = '0;
      for (int n = 0; n < 400; n++) begin
         logic f, v, r, ev, erdy, acc, del;
         logic [CW-1:0] ec;
         logic [DW-1:0] ed;
         f = ($urandom_range(0, 15) == 0);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         drive(f, v, CW'($urandom_range(0, 1023)),
               {$urandom, $urandom, $urandom, $urandom}, r);
         ev   = (q.size() > 0);
         ec   = ev ? q[0].c : '0;
         ed   = ev ? q[0].d : m_last;
         erdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || r);
         expect_out($sformatf("rnd%0d", n), ev, ec, ed,
                    2'(q.size()), erdy);
         acc = v && erdy;
         del = ev && r;
         if (f) begin
            q.delete();
            m_last = '0;
         end else begin
            if (del) begin
               m_last = q[0].d;
               void'(q.pop_front());
            end
            if (acc) q.push_back('{in_ctrl, in_data});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
